// File: rtl/controlador_estabelecidos_pkg.sv
// Shared definitions for the established-flag controller: FSM encoding and
// flag-memory size derivation.
package controlador_estabelecidos_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int mem_size(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/controlador_estabelecidos_arbitro_rr.sv
// Round-robin arbiter: scans requests starting at the priority pointer and
// grants the first one found (one-hot), also reporting its index.
module arbitro_rr #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_in,
    input  logic [PTR_W-1:0]   ptr_in,
    output logic [NUM_REQ-1:0] grant_out,
    output logic [PTR_W-1:0]   grant_idx_out,
    output logic               grant_any_out
);

    always_comb begin
        int  idx;
        logic found;
        grant_out     = '0;
        grant_idx_out = '0;
        found         = 1'b0;
        idx           = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr_in) + k) % NUM_REQ;
            if (!found && req_in[idx]) begin
                grant_out[idx] = 1'b1;
                grant_idx_out  = PTR_W'(idx);
                found          = 1'b1;
            end
        end
        grant_any_out = found;
    end

endmodule

// File: rtl/controlador_estabelecidos.sv
// Established-flag controller: round-robin access from several requesters to
// a flag memory, plus a full clear sweep that zeroes every address.
module controlador_estabelecidos
    import controlador_estabelecidos_pkg::*;
#(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_REQ    = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clear_start_in,
    output logic                             busy_out,
    output logic                             clear_done_out,
    input  logic [NUM_REQ-1:0]               req_valid_in,
    input  logic [NUM_REQ-1:0]               req_write_in,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr_in,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data_in,
    output logic [NUM_REQ-1:0]               req_ready_out,
    output logic [NUM_REQ-1:0]               rsp_valid_out,
    output logic [DATA_WIDTH-1:0]            rsp_data_out,
    output logic                             mem_write_en_out,
    output logic [ADDR_WIDTH-1:0]            mem_write_addr_out,
    output logic [DATA_WIDTH-1:0]            mem_write_data_out,
    output logic                             mem_read_en_out,
    output logic [ADDR_WIDTH-1:0]            mem_read_addr_out,
    input  logic [DATA_WIDTH-1:0]            mem_read_data_in
);

    localparam int PTR_W    = $clog2(NUM_REQ);
    localparam int MEM_SIZE = mem_size(ADDR_WIDTH);
    localparam int CNT_W    = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(MEM_SIZE - 1);

    state_t                 state_q, state_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]  rsp_data_q, rsp_data_d;

    logic [NUM_REQ-1:0]     arb_req;
    logic [NUM_REQ-1:0]     grant;
    logic [PTR_W-1:0]       grant_idx;
    logic                   grant_any;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [DATA_WIDTH-1:0]  sel_data;
    logic                   sel_write;

    // Arbitration only in IDLE; a clear request or reset suppresses all grants.
    assign arb_req = (state_q == IDLE && !clear_start_in && rst_n) ? req_valid_in : '0;

    arbitro_rr #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arbitro_rr (
        .req_in        (arb_req),
        .ptr_in        (ptr_q),
        .grant_out     (grant),
        .grant_idx_out (grant_idx),
        .grant_any_out (grant_any)
    );

    assign sel_addr  = req_addr_in[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_data  = req_data_in[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign sel_write = req_write_in[grant_idx];

    always_comb begin
        state_d            = state_q;
        ptr_d              = ptr_q;
        cnt_d              = cnt_q;
        rsp_valid_d        = '0;
        rsp_data_d         = rsp_data_q;
        mem_write_en_out   = 1'b0;
        mem_write_addr_out = '0;
        mem_write_data_out = '0;
        mem_read_en_out    = 1'b0;
        mem_read_addr_out  = '0;
        case (state_q)
            IDLE: begin
                if (clear_start_in) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end else if (grant_any) begin
                    ptr_d = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
                    if (sel_write) begin
                        mem_write_en_out   = 1'b1;
                        mem_write_addr_out = sel_addr;
                        mem_write_data_out = sel_data;
                    end else begin
                        mem_read_en_out   = 1'b1;
                        mem_read_addr_out = sel_addr;
                        rsp_valid_d       = grant;
                        rsp_data_d        = mem_read_data_in;
                    end
                end
            end
            CLEAR: begin
                mem_write_en_out   = 1'b1;
                mem_write_addr_out = cnt_q[ADDR_WIDTH-1:0];
                mem_write_data_out = '0;
                cnt_d              = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ADDR) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign req_ready_out  = grant;
    assign busy_out       = (state_q == CLEAR) || (state_q == DONE);
    assign clear_done_out = (state_q == DONE);
    assign rsp_valid_out  = rsp_valid_q;
    assign rsp_data_out   = rsp_data_q;

endmodule

// File: tb/tb_controlador_estabelecidos.sv
// Self-checking bench for controlador_estabelecidos: vector table for grants,
// scoreboard for read responses, hand sequences for clear sweep and reset.
module tb_controlador_estabelecidos;

    localparam int NR = 4;
    localparam int AW = 8;
    localparam int DW = 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            clear_start = 1'b0;
    logic [NR-1:0]   req_valid = '0;
    logic [NR-1:0]   req_write = '0;
    logic [NR*AW-1:0] req_addr = '0;
    logic [NR*DW-1:0] req_data = '0;
    logic            busy;
    logic            clear_done;
    logic [NR-1:0]   req_ready;
    logic [NR-1:0]   rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic            mem_write_en;
    logic [AW-1:0]   mem_write_addr;
    logic [DW-1:0]   mem_write_data;
    logic            mem_read_en;
    logic [AW-1:0]   mem_read_addr;
    logic [DW-1:0]   mem_read_data;

    controlador_estabelecidos #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_REQ    (NR)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .clear_start_in     (clear_start),
        .busy_out           (busy),
        .clear_done_out     (clear_done),
        .req_valid_in       (req_valid),
        .req_write_in       (req_write),
        .req_addr_in        (req_addr),
        .req_data_in        (req_data),
        .req_ready_out      (req_ready),
        .rsp_valid_out      (rsp_valid),
        .rsp_data_out       (rsp_data),
        .mem_write_en_out   (mem_write_en),
        .mem_write_addr_out (mem_write_addr),
        .mem_write_data_out (mem_write_data),
        .mem_read_en_out    (mem_read_en),
        .mem_read_addr_out  (mem_read_addr),
        .mem_read_data_in   (mem_read_data)
    );

    always #5 clk = ~clk;

    // Flag memory the DUT talks to: registered write, combinational read.
    bit [DW-1:0] flag_mem [256];
    assign mem_read_data = flag_mem[mem_read_addr];
    always @(posedge clk) begin
        if (mem_write_en) flag_mem[mem_write_addr] <= mem_write_data;
    end

    typedef struct {
        logic [NR-1:0]    valid;
        logic [NR-1:0]    write;
        logic [NR*AW-1:0] addr;
        logic [NR*DW-1:0] data;
        logic             clear;
        logic [NR-1:0]    exp_ready;
    } vec_t;

    typedef struct {
        logic [NR-1:0] valid;
        logic [DW-1:0] data;
    } rsp_t;

    localparam logic [31:0] ADDRS = {8'h13, 8'h12, 8'h11, 8'h10};

    int          err_count = 0;
    int          check_count = 0;
    int          m_state = 0;
    int          m_cnt = 0;
    bit [DW-1:0] ref_mem [256];
    rsp_t        sb_q [$];
    logic [DW-1:0] last_data = '0;
    vec_t        vecs [22];

    function automatic vec_t mk(input logic [3:0] v, input logic [3:0] w, input logic [31:0] a,
                                input logic [3:0] d, input logic c, input logic [3:0] e);
        vec_t r;
        r.valid = v; r.write = w; r.addr = a; r.data = d; r.clear = c; r.exp_ready = e;
        return r;
    endfunction

    function automatic int onehot_idx(input logic [NR-1:0] g);
        int r = 0;
        for (int i = 0; i < NR; i++) if (g[i]) r = i;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_count++;
        if (act !== exp) begin
            err_count++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic checkOutput(input logic [NR-1:0] exp_ready);
        int   gi;
        rsp_t e;
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("busy", 32'(busy), 32'(m_state != 0));
        check("clear_done", 32'(clear_done), 32'(m_state == 2));
        if (m_state == 1) begin
            check("clr_wen", 32'(mem_write_en), 32'd1);
            check("clr_waddr", 32'(mem_write_addr), 32'(m_cnt & 255));
            check("clr_wdata", 32'(mem_write_data), 32'd0);
            check("clr_ren", 32'(mem_read_en), 32'd0);
        end else if (m_state == 0 && exp_ready != '0) begin
            gi = onehot_idx(exp_ready);
            if (req_write[gi]) begin
                check("wr_wen", 32'(mem_write_en), 32'd1);
                check("wr_waddr", 32'(mem_write_addr), 32'(req_addr[gi*AW +: AW]));
                check("wr_wdata", 32'(mem_write_data), 32'(req_data[gi*DW +: DW]));
                check("wr_ren", 32'(mem_read_en), 32'd0);
            end else begin
                check("rd_ren", 32'(mem_read_en), 32'd1);
                check("rd_raddr", 32'(mem_read_addr), 32'(req_addr[gi*AW +: AW]));
                check("rd_wen", 32'(mem_write_en), 32'd0);
            end
        end else begin
            check("idle_wen", 32'(mem_write_en), 32'd0);
            check("idle_ren", 32'(mem_read_en), 32'd0);
        end
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("rsp_valid", 32'(rsp_valid), 32'(e.valid));
            check("rsp_data", 32'(rsp_data), 32'(e.data));
            last_data = e.data;
        end else begin
            check("rsp_valid_idle", 32'(rsp_valid), 32'd0);
            check("rsp_data_hold", 32'(rsp_data), 32'(last_data));
        end
    endtask

    task automatic model_step(input logic [NR-1:0] exp_ready);
        int gi;
        logic [AW-1:0] a;
        case (m_state)
            0: begin
                if (clear_start) begin
                    m_state = 1;
                    m_cnt = 0;
                end else if (exp_ready != '0) begin
                    gi = onehot_idx(exp_ready);
                    a = req_addr[gi*AW +: AW];
                    if (req_write[gi]) ref_mem[a] = req_data[gi*DW +: DW];
                    else sb_q.push_back('{valid: exp_ready, data: ref_mem[a]});
                end
            end
            1: begin
                ref_mem[m_cnt] = '0;
                if (m_cnt == 255) m_state = 2;
                m_cnt++;
            end
            default: m_state = 0;
        endcase
    endtask

    task automatic applyStimulus(input vec_t v);
        req_valid = v.valid;
        req_write = v.write;
        req_addr = v.addr;
        req_data = v.data;
        clear_start = v.clear;
        #2;
        checkOutput(v.exp_ready);
        model_step(v.exp_ready);
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(clear_done), 32'd0);
        check({tag, "_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_wen"}, 32'(mem_write_en), 32'd0);
        check({tag, "_ren"}, 32'(mem_read_en), 32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
    endtask

    initial begin
        vecs[0]  = mk(4'b1000, 4'b0000, ADDRS, 4'b0000, 1'b0, 4'b1000);
        vecs[1]  = mk(4'b0010, 4'b0000, ADDRS, 4'b0000, 1'b0, 4'b0010);
        vecs[2]  = mk(4'b1111, 4'b0000, ADDRS, 4'b0000, 1'b0, 4'b0100);
        vecs[3]  = mk(4'b1111, 4'b0000, ADDRS, 4'b0000, 1'b0, 4'b1000);
        vecs[4]  = mk(4'b1111, 4'b0000, ADDRS, 4'b0000, 1'b0, 4'b0001);
        vecs[5]  = mk(4'b1111, 4'b0000, ADDRS, 4'b0000, 1'b0, 4'b0010);
        vecs[6]  = mk(4'b0100, 4'b0100, {8'h13, 8'h15, 8'h11, 8'h10}, 4'b0100, 1'b0, 4'b0100);
        vecs[7]  = mk(4'b0001, 4'b0000, {8'h13, 8'h12, 8'h11, 8'h15}, 4'b0000, 1'b0, 4'b0001);
        vecs[8]  = mk(4'b0000, 4'b0000, ADDRS, 4'b0000, 1'b0, 4'b0000);
        vecs[9]  = mk(4'b0000, 4'b0000, ADDRS, 4'b0000, 1'b0, 4'b0000);
        vecs[10] = mk(4'b0010, 4'b0010, {8'h13, 8'h12, 8'h20, 8'h10}, 4'b0010, 1'b0, 4'b0010);
        vecs[11] = mk(4'b0011, 4'b0000, {8'h13, 8'h12, 8'h15, 8'h20}, 4'b0000, 1'b0, 4'b0001);
        vecs[12] = mk(4'b0010, 4'b0000, {8'h13, 8'h12, 8'h15, 8'h10}, 4'b0000, 1'b0, 4'b0010);
        vecs[13] = mk(4'b1111, 4'b0000, ADDRS, 4'b0000, 1'b0, 4'b0100);
        vecs[14] = mk(4'b0001, 4'b0000, {8'h13, 8'h12, 8'h11, 8'h15}, 4'b0000, 1'b0, 4'b0001);
        vecs[15] = mk(4'b0000, 4'b0000, ADDRS, 4'b0000, 1'b0, 4'b0000);
        vecs[16] = mk(4'b1111, 4'b0000, ADDRS, 4'b0000, 1'b0, 4'b0001);
        vecs[17] = mk(4'b1111, 4'b0000, ADDRS, 4'b0000, 1'b0, 4'b0010);
        vecs[18] = mk(4'b1111, 4'b0000, ADDRS, 4'b0000, 1'b0, 4'b0100);
        vecs[19] = mk(4'b1111, 4'b0000, ADDRS, 4'b0000, 1'b0, 4'b1000);
        vecs[20] = mk(4'b1111, 4'b0000, ADDRS, 4'b0000, 1'b0, 4'b0001);
        vecs[21] = mk(4'b0000, 4'b0000, ADDRS, 4'b0000, 1'b0, 4'b0000);

        // Reset state, with requests pending that must not be granted.
        req_valid = 4'b1111;
        #1;
        check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = '0;

        // Round-robin, write-then-read, and response hold.
        for (int i = 0; i <= 12; i++) applyStimulus(vecs[i]);

        // Clear wins over pending reads; stray clear pulses in CLEAR/DONE are ignored.
        applyStimulus(mk(4'b1111, 4'b0000, ADDRS, 4'b0000, 1'b1, 4'b0000));
        for (int n = 0; n < 300 && m_state != 0; n++) begin
            applyStimulus(mk(4'b1111, 4'b0000, ADDRS, 4'b0000,
                             (n == 100) || (m_state == 2), 4'b0000));
        end
        if (m_state != 0) check("sweep_bound", 32'(m_state), 32'd0);

        for (int i = 13; i <= 15; i++) applyStimulus(vecs[i]);

        // Reset in the middle of a sweep at address 0x40.
        applyStimulus(mk(4'b0000, 4'b0000, ADDRS, 4'b0000, 1'b1, 4'b0000));
        for (int n = 0; n < 300 && m_cnt < 8'h40; n++) begin
            applyStimulus(mk(4'b0000, 4'b0000, ADDRS, 4'b0000, 1'b0, 4'b0000));
        end
        req_valid = '0;
        clear_start = 1'b0;
        #2;
        checkOutput(4'b0000);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        m_state = 0;
        m_cnt = 0;
        sb_q.delete();
        last_data = '0;
        @(negedge clk);
        #2;
        check_all_zero("held_reset");
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(mk(4'b0000, 4'b0000, ADDRS, 4'b0000, 1'b0, 4'b0000));

        // Grant order restarts from pointer 0 after reset.
        for (int i = 16; i <= 21; i++) applyStimulus(vecs[i]);

        $display("Result: errors=%0d of %0d checks", err_count, check_count);
        $finish;
    end

endmodule

// File: doc/controlador_estabelecidos.md
CONTROLADOR_ESTABELECIDOS -- requirements
Module: controlador_estabelecidos

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 1, width of one established-flag word.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, flag-memory address width; MEM_SIZE = 2**ADDR_WIDTH.
REQ-003 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-004 SHALL have ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- clear_start_in  in  1  one-cycle pulse; requests a full clear sweep.
- busy_out  out  1  high while the clear sweep runs.
- clear_done_out  out  1  one-cycle pulse when the sweep completes.
- req_valid_in  in  NUM_REQ  per-requester access request.
- req_write_in  in  NUM_REQ  per-requester: 1 = write, 0 = read.
- req_addr_in  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at slice i.
- req_data_in  in  NUM_REQ*DATA_WIDTH  packed write data.
- req_ready_out  out  NUM_REQ  one-hot grant.
- rsp_valid_out  out  NUM_REQ  one-hot read-response strobe.
- rsp_data_out  out  DATA_WIDTH  read data, shared by all requesters.
- mem_write_en_out, mem_write_addr_out, mem_write_data_out  out  1/ADDR_WIDTH/DATA_WIDTH  flag-memory write port.
- mem_read_en_out, mem_read_addr_out  out  1/ADDR_WIDTH  flag-memory read port 0.
- mem_read_data_in  in  DATA_WIDTH  combinational read data from the flag memory.

Function
REQ-005 SHALL implement an FSM with states IDLE, CLEAR and DONE.
REQ-006 In IDLE, SHALL grant at most one valid requester per cycle by round-robin; req_ready_out is combinational from req_valid_in and the priority pointer.
REQ-007 After each grant, SHALL move the priority pointer to granted index +1, mod NUM_REQ; with no grant the pointer holds.
REQ-008 Handshake: a transfer occurs when req_valid_in[i] and req_ready_out[i] are both high; the requester holds valid, write, addr and data stable until then.
REQ-009 A granted write SHALL drive mem_write_en_out=1 with the requester's addr and data in the same cycle (combinational).
REQ-010 A granted read SHALL drive mem_read_en_out=1 and the requester's addr in the same cycle, register mem_read_data_in, and pulse rsp_valid_out[i] with rsp_data_out on the next cycle; latency is 1.
REQ-011 rsp_data_out SHALL hold its last value when rsp_valid_out is all zero.
REQ-012 A read granted in the cycle after a write to the same address SHALL return the new data.
REQ-013 In IDLE, clear_start_in SHALL take priority over requests: no grant that cycle, and the next state is CLEAR with sweep counter 0.
REQ-014 In CLEAR, SHALL write {DATA_WIDTH{0}} to address counter each cycle, increment the counter, and issue no grants; after address MEM_SIZE-1 the next state is DONE.
REQ-015 busy_out SHALL be 1 in CLEAR and DONE; clear_done_out SHALL be 1 only in DONE; DONE always moves to IDLE.
REQ-016 clear_start_in SHALL be ignored in CLEAR and DONE.
REQ-017 A read response due the cycle after the entry into CLEAR SHALL still be delivered.
REQ-018 The counter SHALL be ADDR_WIDTH+1 bits wide so the terminal compare does not wrap.

Reset
REQ-019 rst_n low SHALL asynchronously force: state IDLE, pointer 0, counter 0, rsp_valid_out 0, rsp_data_out 0, clear_done_out 0, busy_out 0, and all mem_* enables 0.
REQ-020 Reset during CLEAR SHALL abort the sweep; the memory contents are then undefined until the next clear.

Structure
REQ-021 A shared package SHALL hold the state encoding (IDLE=2'd0, CLEAR=2'd1, DONE=2'd2) and the MEM_SIZE derivation.
REQ-022 Round-robin grant logic SHALL be a sub-module arbitro_rr, parameterised by NUM_REQ, with inputs req/pointer and a one-hot grant output.

Verification
REQ-023 Requester 2 writes addr 0x15 data 1, then requester 0 reads 0x15 on the next cycle -> rsp_valid_out=0001 one cycle after the grant, rsp_data_out=1.
REQ-024 All 4 requesters hold valid reads from reset -> grants in order 0,1,2,3,0, one per cycle.
REQ-025 clear_start_in pulsed with req_valid_in=1111 -> no grant for 257 cycles, busy_out high, 256 zero writes at addresses 0..255, clear_done_out pulse, then grants resume.
REQ-026 rst_n asserted at sweep address 0x40 -> all outputs 0 immediately (asynchronously), state IDLE, no further writes.
REQ-027 Read granted in the same cycle that clear_start_in arrives -> clear_start wins, and the read is granted after DONE.
REQ-028 Only requester 3 valid, then only requester 1 -> grant 1000 then 0010; pointer moves 0 to 0 to 2.
